// File: rtl/pipeline_stall_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use bubbles,
// branch flushes and variable-latency data-memory freeze with timeout.
module pipeline_stall_ctrl #(
    parameter int MEM_TIMEOUT = 15,
    parameter int TO_W        = 4
) (
    input  logic        clock,
    input  logic        rst,
    input  logic        idex_memread,
    input  logic [4:0]  idex_rt,
    input  logic [4:0]  ifid_rs,
    input  logic [4:0]  ifid_rt,
    input  logic        ifid_uses_rt,
    input  logic        branch_taken,
    input  logic        exmem_memop,
    input  logic        dmem_ready,
    output logic        dmem_req,
    output logic        pc_en,
    output logic        ifid_en,
    output logic        idex_en,
    output logic        exmem_en,
    output logic        memwb_en,
    output logic        ifid_flush,
    output logic        idex_flush,
    output logic        memwb_bubble,
    output logic        mem_err,
    output logic [15:0] stall_cnt
);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        ERR      = 2'd2
    } state_t;

    localparam logic [TO_W-1:0] LAST_WAIT = TO_W'(MEM_TIMEOUT - 1);

    state_t          state;
    state_t          stateNext;
    logic [TO_W-1:0] waitCnt;
    logic [TO_W-1:0] waitNext;
    logic [15:0]     stallCnt;
    logic            memErr;

    logic memStall;
    logic brFlush;
    logic loadUse;
    logic luStall;

    assign memStall = exmem_memop && !dmem_ready;

    assign loadUse = idex_memread && (idex_rt != 5'd0) &&
                     ((idex_rt == ifid_rs) ||
                      (ifid_uses_rt && (idex_rt == ifid_rt)));

    // Mutually exclusive so the priority is explicit in the terms.
    assign brFlush = branch_taken && !memStall;
    assign luStall = loadUse && !branch_taken && !memStall;

    always_comb begin
        stateNext    = state;
        waitNext     = waitCnt;
        dmem_req     = 1'b0;
        pc_en        = 1'b1;
        ifid_en      = 1'b1;
        idex_en      = 1'b1;
        exmem_en     = 1'b1;
        memwb_en     = 1'b1;
        ifid_flush   = 1'b0;
        idex_flush   = 1'b0;
        memwb_bubble = 1'b0;
        unique case (state)
            RUN: begin
                dmem_req = exmem_memop;
                unique case (1'b1)
                    memStall: begin
                        pc_en        = 1'b0;
                        ifid_en      = 1'b0;
                        idex_en      = 1'b0;
                        exmem_en     = 1'b0;
                        memwb_bubble = 1'b1;
                        stateNext    = MEM_WAIT;
                        waitNext     = '0;
                    end
                    brFlush: begin
                        ifid_flush = 1'b1;
                        idex_flush = 1'b1;
                    end
                    luStall: begin
                        pc_en      = 1'b0;
                        ifid_en    = 1'b0;
                        idex_flush = 1'b1;
                    end
                    default: ;
                endcase
            end
            MEM_WAIT: begin
                dmem_req = 1'b1;
                if (dmem_ready) begin
                    stateNext = RUN;
                end else begin
                    pc_en        = 1'b0;
                    ifid_en      = 1'b0;
                    idex_en      = 1'b0;
                    exmem_en     = 1'b0;
                    memwb_bubble = 1'b1;
                    if (waitCnt == LAST_WAIT) begin
                        stateNext = ERR;
                    end else begin
                        waitNext = waitCnt + 1'b1;
                    end
                end
            end
            ERR: begin
                pc_en    = 1'b0;
                ifid_en  = 1'b0;
                idex_en  = 1'b0;
                exmem_en = 1'b0;
                memwb_en = 1'b0;
            end
            default: begin
                stateNext = RUN;
            end
        endcase
    end

    always_ff @(posedge clock or negedge rst) begin
        if (!rst) begin
            state    <= RUN;
            waitCnt  <= '0;
            stallCnt <= '0;
            memErr   <= 1'b0;
        end else begin
            state   <= stateNext;
            waitCnt <= waitNext;
            memErr  <= memErr || (stateNext == ERR);
            // Frozen-PC cycles only; a hung memory is not a stall.
            if (!pc_en && (state != ERR) && (stallCnt != 16'hFFFF)) begin
                stallCnt <= stallCnt + 16'd1;
            end
        end
    end

    assign mem_err   = memErr;
    assign stall_cnt = stallCnt;

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// Directed bench for pipeline_stall_ctrl: hazards, flushes, memory
// waits, timeout, reset recovery and stall-counter saturation.
module tb_pipeline_stall_ctrl;

    logic        clock = 1'b0;
    logic        rst = 1'b0;
    logic        idex_memread = 1'b0;
    logic [4:0]  idex_rt = '0;
    logic [4:0]  ifid_rs = '0;
    logic [4:0]  ifid_rt = '0;
    logic        ifid_uses_rt = 1'b0;
    logic        branch_taken = 1'b0;
    logic        exmem_memop = 1'b0;
    logic        dmem_ready = 1'b0;

    logic        dmem_req, pc_en, ifid_en, idex_en, exmem_en, memwb_en;
    logic        ifid_flush, idex_flush, memwb_bubble, mem_err;
    logic [15:0] stall_cnt;

    logic        dmem_req2, pc_en2, ifid_en2, idex_en2, exmem_en2, memwb_en2;
    logic        ifid_flush2, idex_flush2, memwb_bubble2, mem_err2;
    logic [15:0] stall_cnt2;

    int total = 0;
    int bad = 0;

    always #5 clock = ~clock;

    pipeline_stall_ctrl #(.MEM_TIMEOUT(15), .TO_W(4)) dut (
        .clock(clock), .rst(rst),
        .idex_memread(idex_memread), .idex_rt(idex_rt),
        .ifid_rs(ifid_rs), .ifid_rt(ifid_rt),
        .ifid_uses_rt(ifid_uses_rt), .branch_taken(branch_taken),
        .exmem_memop(exmem_memop), .dmem_ready(dmem_ready),
        .dmem_req(dmem_req), .pc_en(pc_en), .ifid_en(ifid_en),
        .idex_en(idex_en), .exmem_en(exmem_en), .memwb_en(memwb_en),
        .ifid_flush(ifid_flush), .idex_flush(idex_flush),
        .memwb_bubble(memwb_bubble), .mem_err(mem_err),
        .stall_cnt(stall_cnt)
    );

    pipeline_stall_ctrl #(.MEM_TIMEOUT(100000), .TO_W(17)) dutBig (
        .clock(clock), .rst(rst),
        .idex_memread(idex_memread), .idex_rt(idex_rt),
        .ifid_rs(ifid_rs), .ifid_rt(ifid_rt),
        .ifid_uses_rt(ifid_uses_rt), .branch_taken(branch_taken),
        .exmem_memop(exmem_memop), .dmem_ready(dmem_ready),
        .dmem_req(dmem_req2), .pc_en(pc_en2), .ifid_en(ifid_en2),
        .idex_en(idex_en2), .exmem_en(exmem_en2), .memwb_en(memwb_en2),
        .ifid_flush(ifid_flush2), .idex_flush(idex_flush2),
        .memwb_bubble(memwb_bubble2), .mem_err(mem_err2),
        .stall_cnt(stall_cnt2)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    task automatic idle();
        idex_memread = 1'b0;
        idex_rt = '0;
        ifid_rs = '0;
        ifid_rt = '0;
        ifid_uses_rt = 1'b0;
        branch_taken = 1'b0;
        exmem_memop = 1'b0;
        dmem_ready = 1'b0;
    endtask

    // enables packed as {pc,ifid,idex,exmem,memwb}
    function automatic logic [4:0] ens();
        return {pc_en, ifid_en, idex_en, exmem_en, memwb_en};
    endfunction

    initial begin
        // reset state
        #3;
        chk("rst_ens", 32'(ens()), 32'h1F);
        chk("rst_flush", {30'd0, ifid_flush, idex_flush}, 32'h0);
        chk("rst_req", 32'(dmem_req), 32'h0);
        chk("rst_bubble", 32'(memwb_bubble), 32'h0);
        chk("rst_cnt", 32'(stall_cnt), 32'h0);
        chk("rst_err", 32'(mem_err), 32'h0);
        @(negedge clock);
        rst = 1'b1;

        // load-use on rs
        cyc();
        idex_memread = 1'b1; idex_rt = 5'd5; ifid_rs = 5'd5;
        #1;
        chk("lu_ens", 32'(ens()), 32'h07);
        chk("lu_flush", {30'd0, ifid_flush, idex_flush}, 32'h1);
        cyc();
        idle();
        #1;
        chk("lu_after_ens", 32'(ens()), 32'h1F);
        chk("lu_after_flush", 32'(idex_flush), 32'h0);
        chk("lu_cnt", 32'(stall_cnt), 32'd1);

        // rt==0 never hazards
        cyc();
        idex_memread = 1'b1; idex_rt = 5'd0; ifid_rs = 5'd0;
        #1;
        chk("lu_r0", 32'(pc_en), 32'h1);
        // rt match ignored unless ID reads rt
        idex_rt = 5'd7; ifid_rs = 5'd3; ifid_rt = 5'd7;
        #1;
        chk("lu_rt_unused", 32'(pc_en), 32'h1);
        ifid_uses_rt = 1'b1;
        #1;
        chk("lu_rt_used", 32'(ens()), 32'h07);
        cyc();
        idle();
        #1;
        chk("lu_rt_cnt", 32'(stall_cnt), 32'd2);

        // branch overrides load-use
        cyc();
        idex_memread = 1'b1; idex_rt = 5'd5; ifid_rs = 5'd5;
        branch_taken = 1'b1;
        #1;
        chk("br_ens", 32'(ens()), 32'h1F);
        chk("br_flush", {30'd0, ifid_flush, idex_flush}, 32'h3);
        cyc();
        idle();
        #1;
        chk("br_cnt", 32'(stall_cnt), 32'd2);

        // 3-wait memory access
        cyc();
        exmem_memop = 1'b1;
        #1;
        chk("m3_c1_ens", 32'(ens()), 32'h01);
        chk("m3_c1_bub", 32'(memwb_bubble), 32'h1);
        chk("m3_c1_req", 32'(dmem_req), 32'h1);
        cyc();
        branch_taken = 1'b1;
        #1;
        chk("m3_c2_ens", 32'(ens()), 32'h01);
        chk("m3_c2_flush", {30'd0, ifid_flush, idex_flush}, 32'h0);
        chk("m3_c2_req", 32'(dmem_req), 32'h1);
        cyc();
        branch_taken = 1'b0;
        #1;
        chk("m3_c3_ens", 32'(ens()), 32'h01);
        chk("m3_c3_bub", 32'(memwb_bubble), 32'h1);
        cyc();
        dmem_ready = 1'b1;
        #1;
        chk("m3_c4_ens", 32'(ens()), 32'h1F);
        chk("m3_c4_bub", 32'(memwb_bubble), 32'h0);
        chk("m3_c4_req", 32'(dmem_req), 32'h1);
        cyc();
        idle();
        #1;
        chk("m3_cnt", 32'(stall_cnt), 32'd5);
        chk("m3_req_off", 32'(dmem_req), 32'h0);

        // zero-wait access
        exmem_memop = 1'b1; dmem_ready = 1'b1;
        #1;
        chk("m0_ens", 32'(ens()), 32'h1F);
        chk("m0_req", 32'(dmem_req), 32'h1);
        cyc();
        idle();
        #1;
        chk("m0_cnt", 32'(stall_cnt), 32'd5);

        // ready on wait cycle 15 beats the timeout
        exmem_memop = 1'b1;
        repeat (15) cyc();
        dmem_ready = 1'b1;
        #1;
        chk("m15_ens", 32'(ens()), 32'h1F);
        cyc();
        idle();
        #1;
        chk("m15_err", 32'(mem_err), 32'h0);
        chk("m15_cnt", 32'(stall_cnt), 32'd20);
        chk("m15_ens_run", 32'(ens()), 32'h1F);

        // timeout: 16 request cycles then ERR
        exmem_memop = 1'b1;
        repeat (15) cyc();
        #1;
        chk("to_c16_ens", 32'(ens()), 32'h01);
        chk("to_c16_err", 32'(mem_err), 32'h0);
        cyc();
        #1;
        chk("to_err", 32'(mem_err), 32'h1);
        chk("to_ens", 32'(ens()), 32'h00);
        chk("to_req", 32'(dmem_req), 32'h0);
        chk("to_cnt", 32'(stall_cnt), 32'd36);
        dmem_ready = 1'b1; branch_taken = 1'b1;
        repeat (3) cyc();
        chk("to_stuck_err", 32'(mem_err), 32'h1);
        chk("to_stuck_ens", 32'(ens()), 32'h00);
        chk("to_stuck_cnt", 32'(stall_cnt), 32'd36);

        // async reset out of ERR
        idle();
        rst = 1'b0;
        #1;
        chk("rerr_err", 32'(mem_err), 32'h0);
        chk("rerr_ens", 32'(ens()), 32'h1F);
        chk("rerr_cnt", 32'(stall_cnt), 32'h0);
        @(negedge clock);
        rst = 1'b1;

        // long stall saturates the counter
        cyc();
        exmem_memop = 1'b1;
        repeat (70000) cyc();
        chk("sat_cnt", 32'(stall_cnt2), 32'hFFFF);
        chk("sat_ens", {27'd0, pc_en2, ifid_en2, idex_en2, exmem_en2,
                        memwb_en2}, 32'h01);
        chk("sat_err", 32'(mem_err2), 32'h0);
        cyc();
        chk("sat_hold", 32'(stall_cnt2), 32'hFFFF);

        // reset while in MEM_WAIT drops the request
        idle();
        #1;
        chk("rwait_req_pre", 32'(dmem_req2), 32'h1);
        rst = 1'b0;
        #1;
        chk("rwait_req", 32'(dmem_req2), 32'h0);
        chk("rwait_cnt", 32'(stall_cnt2), 32'h0);
        @(negedge clock);
        rst = 1'b1;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pipeline_stall_ctrl.md
# pipeline_stall_ctrl

- **Role:** central stall/flush sequencer for the 5-stage MIPS pipeline.
- **Enables:** drives the load enables of PC, IF/ID, ID/EX, EX/MEM and MEM/WB.
- **Bubbles and flushes:** injects bubbles for load-use hazards, flushes on taken branches, and freezes the pipeline while a variable-latency data memory completes.
- **Outputs:** a sticky timeout error and a saturating stall-cycle counter for debug.

## Interface
Parameters:
- MEM_TIMEOUT, 15 — maximum MEM_WAIT cycles before error (≥1)
- TO_W, 4 — width of the wait counter; must satisfy 2^TO_W > MEM_TIMEOUT

Ports:
- clock  in  1  pipeline clock, rising edge
- rst  in  1  asynchronous, active-low reset
- idex_memread  in  1  instruction in EX is a load
- idex_rt  in  5  load destination register in EX
- ifid_rs  in  5  rs of instruction in ID
- ifid_rt  in  5  rt of instruction in ID
- ifid_uses_rt  in  1  ID instruction reads rt
- branch_taken  in  1  branch resolved taken in EX
- exmem_memop  in  1  MEM-stage instruction is a load or store
- dmem_ready  in  1  data memory completes the access this cycle
- dmem_req  out  1  data memory access request
- pc_en, ifid_en, idex_en, exmem_en, memwb_en  out  1 each  stage register load enables
- ifid_flush, idex_flush  out  1 each  load a NOP/zero-control bubble into the stage
- memwb_bubble  out  1  MEM/WB loads zero control (RegWrite=0, MemtoReg=0)
- mem_err  out  1  sticky memory-timeout flag
- stall_cnt  out  16  count of frozen-PC cycles, saturating

## Operation
- **Registered state:**
  - FSM state: RUN, MEM_WAIT, ERR.
  - wait_cnt[TO_W-1:0], stall_cnt, mem_err.
- **Other outputs:** combinational decode of the state and current inputs.
- **Default (RUN, no event):** all enables = 1, flushes = 0, memwb_bubble = 0.
- **dmem_req:** equals exmem_memop in RUN; forced to 1 in MEM_WAIT; 0 in ERR.
- **Memory stall (highest priority):**
  - Trigger: RUN with exmem_memop=1 and dmem_ready=0.
  - Enables: pc_en, ifid_en, idex_en and exmem_en all = 0; memwb_en = 1.
  - memwb_bubble = 1 and all flushes = 0.
  - Next state MEM_WAIT; wait_cnt ← 0.
- **MEM_WAIT:**
  - Same outputs as a memory stall while dmem_ready=0; wait_cnt increments each cycle.
  - dmem_ready=1: outputs are the RUN defaults (pipeline advances, MEM/WB captures the real result); next state RUN.
  - dmem_ready=0 with wait_cnt == MEM_TIMEOUT-1: next state ERR.
  - dmem_ready always wins over the timeout.
  - branch_taken and the load-use hazard are ignored here; they are re-evaluated after resume because EX and ID are held.
- **Branch flush (RUN, no memory stall):**
  - Trigger: branch_taken=1.
  - Response: ifid_flush=1, idex_flush=1, all enables = 1.
  - Overrides a simultaneous load-use hazard.
- **Load-use hazard (RUN, no memory stall, no branch):**
  - Trigger: idex_memread=1, idex_rt≠0, and either idex_rt==ifid_rs, or ifid_uses_rt=1 and idex_rt==ifid_rt.
  - Response: pc_en=0, ifid_en=0, idex_flush=1; the other enables = 1.
- **ERR:**
  - All enables = 0, all flushes = 0, dmem_req = 0, mem_err = 1.
  - Only reset exits ERR.
- **stall_cnt:** +1 on every cycle with pc_en=0 in RUN or MEM_WAIT; saturates at 0xFFFF; does not count in ERR.

## Timing
- **Reset (rst=0, asynchronous):**
  - state = RUN, wait_cnt = 0, stall_cnt = 0, mem_err = 0.
  - Outputs follow the RUN decode; with idle inputs: enables = 1, flushes = 0, dmem_req = 0, memwb_bubble = 0.
- **Reset mid-operation:** rst may assert during MEM_WAIT or ERR; the state returns to RUN immediately and the pending request is dropped.
- **Combinational decode:** enables and flushes respond in the same cycle as the inputs; there is zero latency from hazard detection to stall.
- **Zero-wait memory:** dmem_ready=1 in the first request cycle → no stall and no state change.
- **N-wait memory:** the pipeline is frozen for exactly N cycles; stall_cnt grows by N; the resume cycle is not counted.
- **Timeout:** N ≥ MEM_TIMEOUT+1 cycles without ready. ERR is entered after the 1 RUN cycle plus MEM_TIMEOUT MEM_WAIT cycles; mem_err is high from the next cycle on.
- **Load-use stall:** always exactly 1 cycle. The next cycle sees a bubble in EX (idex_memread=0), which clears the hazard.

## Test plan
- **Reset values:** pulse rst low mid-cycle → all enables = 1, stall_cnt = 0, mem_err = 0 asynchronously; the same holds when reset is asserted from ERR.
- **Load-use hazard:** idex_memread=1, idex_rt=5, ifid_rs=5 for 1 cycle → pc_en=0, ifid_en=0, idex_flush=1 in that cycle only; stall_cnt = 1. Repeat with idex_rt=0 → no stall.
- **Branch flush:** branch_taken=1 together with the load-use condition → ifid_flush=1, idex_flush=1, pc_en=1; stall_cnt unchanged.
- **3-wait memory:** exmem_memop=1, dmem_ready rises on the 4th request cycle → 3 frozen cycles with memwb_bubble=1 and memwb_en=1; dmem_req=1 for 4 cycles; stall_cnt = 3; a branch_taken pulsed during the wait has no effect.
- **Timeout:** MEM_TIMEOUT=15 and dmem_ready held 0 → ERR after 16 request cycles; mem_err=1 and all enables = 0 until rst; dmem_ready=1 arriving on wait cycle 15 resumes normally instead.
- **Counter saturation:** force a 70000-cycle memory stall with MEM_TIMEOUT large → stall_cnt holds at 0xFFFF.
